// File: rtl/bp_be_dep_status_pipe.sv
// Dependency status pipe for the BE execution pipe.
// Each dispatched instruction is recorded as one entry. Entries advance one stage per
// cycle and are published to the hazard detector, together with the busy state of the
// iterative long unit.
module bp_be_dep_status_pipe #(
  parameter int stages_p         = 5,
  parameter int flush_depth_p    = 2,
  parameter int reg_addr_width_p = 5
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     dispatch_v_i,
  input  logic [reg_addr_width_p-1:0]              dispatch_rd_addr_i,
  input  logic                                     dispatch_irf_w_i,
  input  logic                                     dispatch_frf_w_i,
  input  logic [2:0]                               dispatch_pipe_i,
  input  logic                                     dispatch_serial_i,
  input  logic                                     flush_i,
  input  logic                                     long_done_i,
  output logic [stages_p*(reg_addr_width_p+9)-1:0] dep_status_o,
  output logic                                     long_busy_o,
  output logic                                     instr_in_pipe_o
);

  // Pipe codes 6 and 7 are reserved and have no enum member.
  // They match no pipe below, so they behave like int.
  typedef enum logic [2:0] {
    e_pipe_int  = 3'd0,
    e_pipe_aux  = 3'd1,
    e_pipe_mem  = 3'd2,
    e_pipe_mul  = 3'd3,
    e_pipe_fp   = 3'd4,
    e_pipe_long = 3'd5
  } pipe_e;

  typedef struct packed {
    logic                        v;
    logic [reg_addr_width_p-1:0] rd_addr;
    logic                        mem_v;
    logic                        serial_v;
    logic                        mem_iwb_v;
    logic                        mul_iwb_v;
    logic                        fp_iwb_v;
    logic                        aux_fwb_v;
    logic                        mem_fwb_v;
    logic                        fp_fwb_v;
  } dep_entry_s;

  pipe_e                      pipe_li;
  logic                       irf_w_nz;
  dep_entry_s                 entry_n;
  dep_entry_s [stages_p-1:0]  stage_q, stage_n;
  logic                       long_busy_q, long_busy_n;

  assign pipe_li  = pipe_e'(dispatch_pipe_i);
  // A write to x0 creates no hazard, so it never raises an iwb flag.
  assign irf_w_nz = dispatch_irf_w_i & (|dispatch_rd_addr_i);

  // Build the new stage-0 entry from the dispatch inputs; a bubble is all-zero.
  always_comb begin
    entry_n = '0;
    if (dispatch_v_i) begin
      entry_n.v         = 1'b1;
      entry_n.rd_addr   = dispatch_rd_addr_i;
      entry_n.mem_v     = (pipe_li == e_pipe_mem);
      entry_n.serial_v  = dispatch_serial_i;
      entry_n.mem_iwb_v = irf_w_nz & (pipe_li == e_pipe_mem);
      entry_n.mul_iwb_v = irf_w_nz & (pipe_li == e_pipe_mul);
      entry_n.fp_iwb_v  = irf_w_nz & (pipe_li == e_pipe_fp);
      entry_n.aux_fwb_v = dispatch_frf_w_i & (pipe_li == e_pipe_aux);
      entry_n.mem_fwb_v = dispatch_frf_w_i & (pipe_li == e_pipe_mem);
      entry_n.fp_fwb_v  = dispatch_frf_w_i & (pipe_li == e_pipe_fp);
    end
  end

  // Shift every stage by one. A flush zeroes the new entry and the shallow stages,
  // but entries past commit keep moving.
  always_comb begin
    stage_n    = '0;
    stage_n[0] = flush_i ? '0 : entry_n;
    for (int unsigned i = 1; i < stages_p; i++) begin
      stage_n[i] = (flush_i && (i < flush_depth_p)) ? '0 : stage_q[i-1];
    end
  end

  // A new long op takes priority over a completion in the same cycle.
  // A flush does not release an op that was already accepted.
  always_comb begin
    long_busy_n = long_busy_q;
    if (dispatch_v_i && (pipe_li == e_pipe_long) && !flush_i) begin
      long_busy_n = 1'b1;
    end else if (long_done_i) begin
      long_busy_n = 1'b0;
    end
  end

  // State registers; an asynchronous reset discards everything in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stage_q     <= '0;
      long_busy_q <= 1'b0;
    end else begin
      stage_q     <= stage_n;
      long_busy_q <= long_busy_n;
    end
  end

  // Any valid entry short of the last writeback stage counts as in flight.
  always_comb begin
    instr_in_pipe_o = 1'b0;
    for (int unsigned i = 0; i < stages_p - 1; i++) begin
      instr_in_pipe_o = instr_in_pipe_o | stage_q[i].v;
    end
  end

  assign dep_status_o = stage_q;
  assign long_busy_o  = long_busy_q;

  // The detector must not dispatch a second long op while the unit is occupied.
  // A completion in the same cycle frees the unit for the new op.
  long_dispatch_while_busy: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
      !(long_busy_q && !long_done_i && dispatch_v_i && (pipe_li == e_pipe_long))
  );

endmodule

// File: tb/tb_bp_be_dep_status_pipe.sv
// Directed bench for bp_be_dep_status_pipe with hand-computed expected entries.
module tb_bp_be_dep_status_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_v, d_irf, d_frf, d_ser, flush, ldone;
  logic [4:0]  d_rd;
  logic [2:0]  d_pipe;
  logic [69:0] dep;
  logic        busy, inpipe;

  int vectors = 0;
  int errs    = 0;

  bp_be_dep_status_pipe #(
    .stages_p(5),
    .flush_depth_p(2),
    .reg_addr_width_p(5)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .dispatch_v_i(d_v),
    .dispatch_rd_addr_i(d_rd),
    .dispatch_irf_w_i(d_irf),
    .dispatch_frf_w_i(d_frf),
    .dispatch_pipe_i(d_pipe),
    .dispatch_serial_i(d_ser),
    .flush_i(flush),
    .long_done_i(ldone),
    .dep_status_o(dep),
    .long_busy_o(busy),
    .instr_in_pipe_o(inpipe)
  );

  always #5 clk = ~clk;

  // flags, MSB->LSB: mem_v serial_v mem_iwb mul_iwb fp_iwb aux_fwb mem_fwb fp_fwb
  function automatic logic [13:0] mk(input logic [4:0] rd, input logic [7:0] flags);
    return {1'b1, rd, flags};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stage(input string tag, input int s, input logic [13:0] exp);
    chk(tag, 70'(dep[s*14 +: 14]), 70'(exp));
  endtask

  task automatic disp(input logic [4:0] rd, input logic irf, input logic frf,
                      input logic [2:0] pipe, input logic ser);
    d_v = 1'b1; d_rd = rd; d_irf = irf; d_frf = frf; d_pipe = pipe; d_ser = ser;
  endtask

  // Bubble with garbage on the ignored dispatch fields.
  task automatic idle();
    d_v = 1'b0; d_rd = 5'd31; d_irf = 1'b1; d_frf = 1'b1; d_pipe = 3'd2; d_ser = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [13:0] e_ld5, e_x0, e_f3, e_div4, e_csr;

  initial begin
    e_ld5  = mk(5'd5, 8'b1010_0000);
    e_x0   = mk(5'd0, 8'b0000_0000);
    e_f3   = mk(5'd3, 8'b0000_0001);
    e_div4 = mk(5'd4, 8'b0000_0000);
    e_csr  = mk(5'd9, 8'b0100_0000);

    rst_n = 1'b0; flush = 1'b0; ldone = 1'b0;
    idle();
    #12;
    chk("reset_dep", dep, '0);
    chk("reset_busy", 70'(busy), 70'(0));
    chk("reset_inpipe", 70'(inpipe), 70'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: mem load x5 walks through all five stages
    disp(5'd5, 1'b1, 1'b0, 3'd2, 1'b0);
    tick(); idle();
    chk("ld_stage0", dep, 70'(e_ld5));
    chk("ld_inpipe_s0", 70'(inpipe), 70'(1));
    tick(); chk_stage("ld_stage1", 1, e_ld5);
    tick(); chk_stage("ld_stage2", 2, e_ld5);
    tick(); chk_stage("ld_stage3", 3, e_ld5);
    chk("ld_inpipe_s3", 70'(inpipe), 70'(1));
    tick(); chk("ld_stage4", dep, {e_ld5, 56'd0});
    chk("ld_inpipe_s4", 70'(inpipe), 70'(0));
    tick(); chk("ld_drained", dep, '0);

    // 2: writes to x0 raise no iwb flags; mul x7 does
    disp(5'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    disp(5'd0, 1'b1, 1'b0, 3'd3, 1'b0);
    tick();
    chk("x0_pair", dep, 70'({e_x0, e_x0}));
    disp(5'd7, 1'b1, 1'b0, 3'd3, 1'b0);
    tick();
    chk_stage("mul_x7", 0, mk(5'd7, 8'b0001_0000));
    // serializing CSR on reserved pipe code 6 with irf_w
    disp(5'd9, 1'b1, 1'b0, 3'd6, 1'b1);
    tick(); idle();
    chk_stage("csr_reserved", 0, e_csr);
    tick(); tick(); tick(); tick(); tick();
    chk("x0_drained", dep, '0);

    // 3: four fadd f3, flush with the fourth
    for (int k = 0; k < 4; k++) begin
      disp(5'd3, 1'b0, 1'b1, 3'd4, 1'b0);
      flush = (k == 3);
      tick();
    end
    idle(); flush = 1'b0;
    chk("flush_stages", dep, {14'd0, e_f3, e_f3, 28'd0});
    chk("flush_inpipe", 70'(inpipe), 70'(1));
    tick(); tick(); tick();
    chk("flush_drained", dep, '0);

    // 4: div x4 holds long_busy until long_done
    disp(5'd4, 1'b1, 1'b0, 3'd5, 1'b0);
    tick(); idle();
    chk("div_busy_c1", 70'(busy), 70'(1));
    chk("div_entry", dep, 70'(e_div4));
    for (int k = 0; k < 19; k++) tick();
    chk("div_busy_c20", 70'(busy), 70'(1));
    ldone = 1'b1;
    tick(); ldone = 1'b0;
    chk("div_done_c21", 70'(busy), 70'(0));

    // 5: done plus new div in the same cycle keeps busy; flushed div never sets it
    disp(5'd4, 1'b1, 1'b0, 3'd5, 1'b0);
    tick();
    ldone = 1'b1;
    tick(); ldone = 1'b0; idle();
    chk("done_and_div", 70'(busy), 70'(1));
    ldone = 1'b1;
    tick(); ldone = 1'b0;
    chk("done_alone", 70'(busy), 70'(0));
    disp(5'd4, 1'b1, 1'b0, 3'd5, 1'b0);
    flush = 1'b1;
    tick(); flush = 1'b0; idle();
    chk("flushed_div_busy", 70'(busy), 70'(0));
    chk_stage("flushed_div_entry", 0, 14'd0);
    disp(5'd4, 1'b1, 1'b0, 3'd5, 1'b0);
    tick(); idle();
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush_keeps_busy", 70'(busy), 70'(1));
    ldone = 1'b1;
    tick(); ldone = 1'b0;
    chk("busy_released", 70'(busy), 70'(0));
    tick(); tick(); tick(); tick();

    // 6: async reset with five valid entries and a busy long unit
    for (int k = 1; k <= 4; k++) begin
      disp(5'(k), 1'b1, 1'b0, 3'd0, 1'b0);
      tick();
    end
    disp(5'd5, 1'b1, 1'b0, 3'd5, 1'b0);
    tick(); idle();
    chk("full_pipe", dep, {mk(5'd1, 8'd0), mk(5'd2, 8'd0), mk(5'd3, 8'd0),
                           mk(5'd4, 8'd0), mk(5'd5, 8'd0)});
    chk("full_busy", 70'(busy), 70'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dep", dep, '0);
    chk("async_rst_busy", 70'(busy), 70'(0));
    chk("async_rst_inpipe", 70'(inpipe), 70'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", dep, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
